bit_scan_encoder: RTL and testbench

BIT_SCAN_ENCODER -- requirements
Module: bit_scan_encoder

---
 rtl/bit_scan_pkg.sv | 19 +
 rtl/bit_scan_encoder_prio_enc.sv | 40 ++++
 rtl/bit_scan_encoder.sv | 109 ++++++++++
 tb/tb_bit_scan_encoder.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bit_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bit_scan_pkg
// Brief    : Shared types and constants for the bit-scan encoder.
// Revision : 1.0 - initial release
// ============================================================================
package bit_scan_pkg;

    // Default request-vector width.
    localparam int DEFAULT_WIDTH = 16;

    // Two-state controller: waiting for a vector, or draining its set bits.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/bit_scan_encoder_prio_enc.sv
`default_nettype none
// ============================================================================
// Module   : prio_enc
// Brief    : Combinational lowest-set-bit encoder. Reports the index of the
//            lowest set bit, whether any bit is set, and whether exactly one
//            bit is set.
// Revision : 1.0 - initial release
// ============================================================================
module prio_enc
    import bit_scan_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int IDXW  = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    output logic [IDXW-1:0]  idx,
    output logic             any,
    output logic             single
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IDXW'(i);
            end
        end
    end

    // Exactly one bit set <=> nonzero and clearing the lowest bit leaves zero.
    always_comb begin
        any    = |vec;
        single = any && ((vec & (vec - ONE)) == '0);
    end

endmodule
`default_nettype wire

// File: rtl/bit_scan_encoder.sv
`default_nettype none
// ============================================================================
// Module   : bit_scan_encoder
// Brief    : Accepts a WIDTH-bit request vector and emits one binary index
//            beat per set bit, lowest index first, over a valid/ready stream.
//            Optional macro ZERO_FLAG_EN: an all-zero vector yields a single
//            beat with out_none=1 instead of being dropped.
// Revision : 1.0 - initial release
// ============================================================================
module bit_scan_encoder
    import bit_scan_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int IDXW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_vec,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [IDXW-1:0]  out_idx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             out_none
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] pending;
    logic [WIDTH-1:0] pending_nxt;
    logic [IDXW-1:0]  enc_idx;
    logic             enc_any;
    logic             enc_single;
    logic             emitting;

    // Lowest-set-bit decode of the pending vector; all outputs come from here.
    prio_enc #(
        .WIDTH (WIDTH)
    ) u_prio_enc (
        .vec    (pending),
        .idx    (enc_idx),
        .any    (enc_any),
        .single (enc_single)
    );

    // State and pending-bit registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pending <= '0;
        end else begin
            state   <= state_nxt;
            pending <= pending_nxt;
        end
    end

    // Output decode from registered state only. An empty pending vector while
    // emitting can only be the zero-flag beat, which is also the last beat.
    always_comb begin
        emitting  = (state == EMIT);
        in_ready  = (state == IDLE);
        out_valid = emitting;
        out_idx   = emitting ? enc_idx : '0;
        out_last  = emitting && (enc_single || !enc_any);
`ifdef ZERO_FLAG_EN
        out_none  = emitting && !enc_any;
`else
        out_none  = 1'b0;
`endif
    end

    // Next-state logic: latch a vector in IDLE, peel off one bit per beat in EMIT.
    always_comb begin
        state_nxt   = state;
        pending_nxt = pending;
        case (state)
            IDLE: begin
                if (in_valid) begin
`ifdef ZERO_FLAG_EN
                    state_nxt   = EMIT;
                    pending_nxt = in_vec;
`else
                    if (in_vec != '0) begin
                        state_nxt   = EMIT;
                        pending_nxt = in_vec;
                    end
`endif
                end
            end
            EMIT: begin
                if (out_ready) begin
                    pending_nxt = pending & (pending - ONE);
                    if (out_last) begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt   = IDLE;
                pending_nxt = '0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_bit_scan_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_bit_scan_encoder
// Brief    : Self-checking bench for bit_scan_encoder with an expected-beat
//            queue model, directed scenarios and randomized traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bit_scan_encoder;

    localparam int WIDTH = 16;
    localparam int IDXW  = 4;

    typedef struct {
        int idx;
        bit last;
        bit none;
    } beat_t;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] in_vec;
    logic             in_valid;
    logic             in_ready;
    logic [IDXW-1:0]  out_idx;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;
    logic             out_none;

    int    tests = 0;
    int    fails = 0;
    int    hs_count = 0;
    bit    rand_ready = 0;
    beat_t q[$];

    bit_scan_encoder #(
        .WIDTH (WIDTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_vec    (in_vec),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_idx   (out_idx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .out_none  (out_none)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Expected beats for one accepted vector: every set bit, ascending.
    function automatic void expand(input logic [WIDTH-1:0] v);
        int cnt;
        int seen;
        beat_t b;
        cnt  = $countones(v);
        seen = 0;
        for (int i = 0; i < WIDTH; i++) begin
            if (v[i]) begin
                seen++;
                b.idx  = i;
                b.last = (seen == cnt);
                b.none = 1'b0;
                q.push_back(b);
            end
        end
`ifdef ZERO_FLAG_EN
        if (cnt == 0) begin
            b.idx  = 0;
            b.last = 1'b1;
            b.none = 1'b1;
            q.push_back(b);
        end
`endif
    endfunction

    // Compare process: outputs are checked against the model between edges,
    // then the model is advanced for the coming rising edge.
    always @(negedge clk) begin
        bit idle;
        if (!rst_n) begin
            q.delete();
            check("rst_out_valid", int'(out_valid), 0);
            check("rst_out_idx",   int'(out_idx),   0);
            check("rst_out_last",  int'(out_last),  0);
            check("rst_out_none",  int'(out_none),  0);
        end else begin
            idle = (q.size() == 0);
            check("in_ready",  int'(in_ready),  int'(idle));
            check("out_valid", int'(out_valid), int'(!idle));
            if (!idle && out_valid) begin
                check("out_idx",  int'(out_idx),  q[0].idx);
                check("out_last", int'(out_last), int'(q[0].last));
                check("out_none", int'(out_none), int'(q[0].none));
                if (out_ready) begin
                    void'(q.pop_front());
                    hs_count++;
                end
            end
            if (idle && in_valid) begin
                expand(in_vec);
            end
        end
    end

    // Random backpressure when enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send(input logic [WIDTH-1:0] v);
        int n;
        n = 0;
        in_vec   = v;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_vec   = WIDTH'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", int'(q.size() != 0), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;
        logic [WIDTH-1:0] v;

        rst_n     = 1'b0;
        in_vec    = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;

        // Pin the model with hand-derived beat lists.
        expand(16'h8421);
        check("model_8421_size", q.size(), 4);
        check("model_8421_b0",   q[0].idx, 0);
        check("model_8421_b1",   q[1].idx, 5);
        check("model_8421_b2",   q[2].idx, 10);
        check("model_8421_b3",   q[3].idx, 15);
        check("model_8421_last3", int'(q[3].last), 1);
        check("model_8421_last2", int'(q[2].last), 0);
        q.delete();
        expand(16'h8000);
        check("model_8000_idx",  q[0].idx, 15);
        check("model_8000_last", int'(q[0].last), 1);
        q.delete();

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single lowest bit.
        send(16'h0001);
        drain();
        // Spread bits, drained back to back.
        send(16'h8421);
        drain();
        // Backpressure on the first beat.
        out_ready = 1'b0;
        send(16'h0102);
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
        drain();
        // All-zero vector.
        base = hs_count;
        send(16'h0000);
        repeat (3) @(posedge clk);
        #1;
`ifdef ZERO_FLAG_EN
        check("zero_beats", hs_count - base, 1);
`else
        check("zero_beats", hs_count - base, 0);
`endif
        // Top bit only.
        send(16'h8000);
        drain();
        // Reset in the middle of an all-ones drain.
        base = hs_count;
        send(16'hFFFF);
        n = 0;
        while (hs_count < base + 3 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("ffff_pre_reset_beats", hs_count - base, 3);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_valid", int'(out_valid), 0);
        check("async_rst_last",  int'(out_last),  0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        base = hs_count;
        repeat (5) @(posedge clk);
        #1;
        check("post_reset_beats", hs_count - base, 0);
        // Full all-ones drain.
        base = hs_count;
        send(16'hFFFF);
        drain();
        check("ffff_beats", hs_count - base, 16);
        // Second vector offered while the first is still draining.
        base = hs_count;
        send(16'h0003);
        send(16'h0010);
        drain();
        check("overlap_beats", hs_count - base, 3);

        // Randomized traffic with random backpressure.
        rand_ready = 1'b1;
        repeat (150) begin
            case ($urandom_range(0, 5))
                0: v = WIDTH'($urandom);
                1: v = WIDTH'(1) << $urandom_range(0, WIDTH - 1);
                2: v = '1;
                3: v = '0;
                4: v = WIDTH'($urandom & $urandom & $urandom);
                default: v = 16'h8000;
            endcase
            send(v);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        drain();
        rand_ready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
